// File: rtl/signext_arbiter_pkg.sv
// rtl/signext_arbiter_pkg.sv - shared types, defaults and helpers for signext_arbiter
package signext_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH_IN  = 16;
    localparam int DEF_DEPTH          = 2;
    localparam int DEF_DATA_WIDTH_OUT = 32;
    localparam int DEF_DELAY          = 2;
    localparam int DEF_NUM_REQ        = 4;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_NUM_REQ);

endpackage

// File: rtl/signext_arbiter_rr_arbiter.sv
// rtl/signext_arbiter_rr_arbiter.sv - round-robin one-hot grant starting after a pointer
module rr_arbiter
    import signext_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan ptr+1, ptr+2, ... wrapping, and grant the first active request.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/signext_arbiter.sv
// rtl/signext_arbiter.sv - arbitrates requesters onto a shared external sign-extend datapath
module signext_arbiter
    import signext_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = DEF_DATA_WIDTH_IN,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int DATA_WIDTH_OUT = DEF_DATA_WIDTH_OUT,
    parameter int DELAY          = DEF_DELAY,
    parameter int NUM_REQ        = DEF_NUM_REQ
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_signed,
    input  logic [NUM_REQ*DEPTH*DATA_WIDTH_IN-1:0] req_data,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic                                  flush,
    output logic                                  flush_done,
    output logic [DEPTH*DATA_WIDTH_IN-1:0]        se_dataIn,
    output logic                                  se_IsSigned,
    output logic                                  se_en_n,
    input  logic [DEPTH*DATA_WIDTH_OUT-1:0]       se_dataOut,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [DEPTH*DATA_WIDTH_OUT-1:0]       rsp_data,
    output logic                                  busy
);

    localparam int IDX_W   = idx_width(NUM_REQ);
    localparam int CNT_W   = $clog2(DELAY + 2);
    localparam int WORD_IN = DEPTH * DATA_WIDTH_IN;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [IDX_W-1:0] last_grant_q;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               allow;
    logic               transfer;
    logic               rsp_fire;
    logic               last_vld;
    logic [IDX_W-1:0]   last_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i     (req_valid),
        .ptr_i     (last_grant_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign allow     = !rst && !en_n && (state_q != ST_DRAIN);
    assign req_ready = allow ? gnt : '0;
    assign transfer  = |req_ready;
    assign se_en_n   = en_n;
    assign rsp_data  = se_dataOut;
    assign busy      = !rst && ((inflight_q != '0) || (state_q != ST_IDLE));

    // Steer the granted word and sign select to the datapath; zero when idle.
    always_comb begin
        se_dataIn   = '0;
        se_IsSigned = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready[k]) begin
                se_dataIn   = req_data[k*WORD_IN +: WORD_IN];
                se_IsSigned = req_signed[k];
            end
        end
    end

    if (DELAY > 0) begin : g_tags
        logic [DELAY-1:0] tag_vld_q;
        logic [IDX_W-1:0] tag_idx_q [DELAY];

        // Tag shift register mirrors the datapath latency; stalls with en_n.
        always_ff @(posedge clk) begin
            if (rst) begin
                tag_vld_q <= '0;
                for (int i = 0; i < DELAY; i++) begin
                    tag_idx_q[i] <= '0;
                end
            end else if (!en_n) begin
                tag_vld_q[0] <= transfer;
                tag_idx_q[0] <= gnt_idx;
                for (int i = 1; i < DELAY; i++) begin
                    tag_vld_q[i] <= tag_vld_q[i-1];
                    tag_idx_q[i] <= tag_idx_q[i-1];
                end
            end
        end

        assign last_vld = tag_vld_q[DELAY-1];
        assign last_idx = tag_idx_q[DELAY-1];
    end else begin : g_no_tags
        assign last_vld = transfer;
        assign last_idx = gnt_idx;
    end

    // Decode the oldest tag into the one-hot response strobe.
    always_comb begin
        rsp_valid = '0;
        if (last_vld && !en_n && !rst) begin
            rsp_valid[last_idx] = 1'b1;
        end
    end

    assign rsp_fire = |rsp_valid;

    // Count outstanding transfers; simultaneous issue and retire cancel out.
    always_comb begin
        inflight_d = inflight_q;
        if (transfer && !rsp_fire) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!transfer && rsp_fire) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // Next-state logic; a stalled or resetting block neither moves nor reports a drain.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        if (!rst && !en_n) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (flush) begin
                        state_d = ST_DRAIN;
                    end else if (transfer) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_d = ST_DRAIN;
                    end else if ((inflight_q == '0) && !transfer) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (inflight_q == '0) begin
                        state_d    = ST_IDLE;
                        flush_done = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, occupancy and arbitration pointer; frozen while en_n is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inflight_q   <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else if (!en_n) begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            if (transfer) begin
                last_grant_q <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_signext_arbiter.sv
// tb/tb_signext_arbiter.sv - scoreboard bench for signext_arbiter (DELAY=2 and DELAY=0 builds)
module tb_signext_arbiter;

    typedef struct packed {
        logic [3:0]  oh;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_signed;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic        flush;
    logic        flush_done;
    logic [31:0] se_dataIn;
    logic        se_IsSigned;
    logic        se_en_n;
    logic [63:0] se_dataOut;
    logic [3:0]  rsp_valid;
    logic [63:0] rsp_data;
    logic        busy;

    logic        en_n0;
    logic [3:0]  req_valid0;
    logic [3:0]  req_ready0;
    logic        flush0;
    logic        flush_done0;
    logic [31:0] se_dataIn0;
    logic        se_IsSigned0;
    logic        se_en_n0;
    logic [63:0] se_dataOut0;
    logic [3:0]  rsp_valid0;
    logic [63:0] rsp_data0;
    logic        busy0;

    logic [63:0] dp_s0, dp_s1;
    logic [63:0] exp_data [4];
    exp_t        sb_q[$];
    exp_t        sb0_q[$];
    int          en_cyc = 0;
    int          checks = 0;
    int          errors = 0;

    signext_arbiter #(.DATA_WIDTH_IN(16), .DEPTH(2), .DATA_WIDTH_OUT(32), .DELAY(2), .NUM_REQ(4)) u_dut (
        .clk(clk), .rst(rst), .en_n(en_n), .req_valid(req_valid), .req_signed(req_signed),
        .req_data(req_data), .req_ready(req_ready), .flush(flush), .flush_done(flush_done),
        .se_dataIn(se_dataIn), .se_IsSigned(se_IsSigned), .se_en_n(se_en_n), .se_dataOut(se_dataOut),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    signext_arbiter #(.DATA_WIDTH_IN(16), .DEPTH(2), .DATA_WIDTH_OUT(32), .DELAY(0), .NUM_REQ(4)) u_dut0 (
        .clk(clk), .rst(rst), .en_n(en_n0), .req_valid(req_valid0), .req_signed(req_signed),
        .req_data(req_data), .req_ready(req_ready0), .flush(flush0), .flush_done(flush_done0),
        .se_dataIn(se_dataIn0), .se_IsSigned(se_IsSigned0), .se_en_n(se_en_n0), .se_dataOut(se_dataOut0),
        .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .busy(busy0)
    );

    function automatic logic [63:0] sext(input logic [31:0] w, input logic s);
        logic [63:0] r;
        logic [15:0] lane;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            lane = w[l*16 +: 16];
            r[l*32 +: 32] = {{16{s & lane[15]}}, lane};
        end
        return r;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (se_en_n == 1'b0) begin
            dp_s0 <= sext(se_dataIn, se_IsSigned);
            dp_s1 <= dp_s0;
        end
    end
    assign se_dataOut  = dp_s1;
    assign se_dataOut0 = se_en_n0 ? 64'h0 : sext(se_dataIn0, se_IsSigned0);

    always @(posedge clk) begin
        if (en_n == 1'b0) en_cyc <= en_cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] oh, input bit zero_lat);
        exp_t e;
        e.oh   = oh;
        e.data = '0;
        for (int k = 0; k < 4; k++) if (oh[k]) e.data = exp_data[k];
        e.due  = en_cyc + (zero_lat ? 0 : 2);
        if (zero_lat) sb0_q.push_back(e);
        else          sb_q.push_back(e);
    endtask

    task automatic step(input logic en_v, input logic [3:0] vld, input logic fl,
                        input logic [3:0] exp_rdy, input logic exp_fd, input logic exp_busy);
        en_n = en_v; req_valid = vld; flush = fl;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("flush_done", 64'(flush_done), 64'(exp_fd));
        chk("busy", 64'(busy), 64'(exp_busy));
        if (exp_rdy != 4'b0) push(exp_rdy, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic step0(input logic [3:0] vld, input logic [3:0] exp_rdy, input logic exp_busy);
        req_valid0 = vld;
        @(negedge clk);
        chk("req_ready0", 64'(req_ready0), 64'(exp_rdy));
        chk("flush_done0", 64'(flush_done0), 64'(1'b0));
        chk("busy0", 64'(busy0), 64'(exp_busy));
        if (exp_rdy != 4'b0) push(exp_rdy, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic rst_step(input logic [3:0] vld);
        rst = 1'b1; req_valid = vld; req_valid0 = vld;
        sb_q.delete(); sb0_q.delete();
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(4'b0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(4'b0));
        chk("rst_flush_done", 64'(flush_done), 64'(1'b0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_req_ready0", 64'(req_ready0), 64'(4'b0));
        chk("rst_rsp_valid0", 64'(rsp_valid0), 64'(4'b0));
        @(posedge clk); #1;
        rst = 1'b0; req_valid0 = 4'b0;
    endtask

    task automatic idle(input int n, input logic last_busy);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0, 1'b0, 4'b0, 1'b0, (i == n-1) ? last_busy : 1'b1);
    endtask

    always begin : mon
        exp_t e;
        @(negedge clk); #2;
        if (rsp_valid != 4'b0) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: got %b expected none at %0t", rsp_valid, $time);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(e.oh));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_latency", 64'(en_cyc), 64'(e.due));
            end
        end
        if (rsp_valid0 != 4'b0) begin
            if (sb0_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp0_unexpected: got %b expected none at %0t", rsp_valid0, $time);
            end else begin
                e = sb0_q.pop_front();
                chk("rsp_valid0", 64'(rsp_valid0), 64'(e.oh));
                chk("rsp_data0", rsp_data0, e.data);
                chk("rsp_latency0", 64'(en_cyc), 64'(e.due));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_data[0] = {32'h00007FFF, 32'hFFFF8000};
        exp_data[1] = {32'h0000FFFF, 32'h00001234};
        exp_data[2] = {32'h00000001, 32'hFFFF8001};
        exp_data[3] = {32'hFFFFC000, 32'h000000FF};
        req_data    = {32'hC00000FF, 32'h00018001, 32'hFFFF1234, 32'h7FFF8000};
        req_signed  = 4'b1101;
        rst = 1'b1; en_n = 1'b0; req_valid = 4'hF; flush = 1'b0;
        en_n0 = 1'b0; req_valid0 = 4'b0; flush0 = 1'b0;

        rst_step(4'hF);
        rst_step(4'hF);

        // round robin from requester 0, continuous requests
        step(0, 4'hF, 0, 4'b0001, 0, 0);
        step(0, 4'hF, 0, 4'b0010, 0, 1);
        step(0, 4'hF, 0, 4'b0100, 0, 1);
        step(0, 4'hF, 0, 4'b1000, 0, 1);
        step(0, 4'hF, 0, 4'b0001, 0, 1);
        step(0, 4'hF, 0, 4'b0010, 0, 1);
        step(0, 4'hF, 0, 4'b0100, 0, 1);
        step(0, 4'hF, 0, 4'b1000, 0, 1);
        idle(4, 1'b0);

        // single signed request from requester 2
        step(0, 4'b0100, 0, 4'b0100, 0, 0);
        idle(4, 1'b0);

        // stall for three cycles mid-stream
        step(0, 4'hF, 0, 4'b1000, 0, 0);
        step(0, 4'hF, 0, 4'b0001, 0, 1);
        step(1, 4'hF, 0, 4'b0000, 0, 1);
        step(1, 4'hF, 0, 4'b0000, 0, 1);
        step(1, 4'hF, 0, 4'b0000, 0, 1);
        step(0, 4'hF, 0, 4'b0010, 0, 1);
        step(0, 4'hF, 0, 4'b0100, 0, 1);
        idle(4, 1'b0);

        // flush coincident with a grant, repeated flush in DRAIN ignored
        step(0, 4'hF, 0, 4'b1000, 0, 0);
        step(0, 4'hF, 1, 4'b0001, 0, 1);
        step(0, 4'hF, 1, 4'b0000, 0, 1);
        step(0, 4'hF, 0, 4'b0000, 0, 1);
        step(0, 4'hF, 0, 4'b0000, 1, 1);
        step(0, 4'hF, 0, 4'b0010, 0, 0);
        step(0, 4'hF, 0, 4'b0100, 0, 1);

        // reset with two transfers in flight
        rst_step(4'hF);
        step(0, 4'b0, 0, 4'b0000, 0, 0);
        step(0, 4'b0, 0, 4'b0000, 0, 0);
        step(0, 4'hF, 0, 4'b0001, 0, 0);
        idle(4, 1'b0);

        // zero-latency build
        step0(4'b0010, 4'b0010, 0);
        step0(4'b1010, 4'b1000, 1);
        step0(4'b0001, 4'b0001, 1);
        step0(4'b0000, 4'b0000, 1);
        step0(4'b0000, 4'b0000, 0);

        @(negedge clk); #4;
        chk("sb_pending", 64'(sb_q.size()), 64'd0);
        chk("sb0_pending", 64'(sb0_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
